aes_key_sched: RTL and testbench

Iterative AES key-expansion controller. It takes a cipher key on a start pulse and streams the expanded key schedule w[0..Nw-1] one 32-bit word per cycle over a valid/ready handshake. It sequences a single shared SubWord unit together with rotate and round-constant logic, and feeds the round-key store of the encrypt/decrypt cores. It supports 128-, 192- and 256-bit keys, selected at elaboration time.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_key_sched_sub_word.sv | 13 +
 rtl/aes_key_sched.sv | 151 +++++++++++++++
 tb/tb_aes_key_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size constants, word type, xtime and the S-box byte map.
// Used by the key schedule and the cipher datapath.
package aes_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } ks_state_t;

    localparam byte_t RCON_INIT = 8'h01;

    function automatic int NK(input int key_size);
        return key_size / 32;
    endfunction

    function automatic int NR(input int key_size);
        return NK(key_size) + 6;
    endfunction

    function automatic int NW(input int key_size);
        return 4 * (NR(key_size) + 1);
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_sched_sub_word.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: streams w[0..Nw-1] one word per handshake, using a
// sliding window of the last Nk words and a single shared SubWord unit.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_SIZE = 128
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         wk_valid,
    input  logic         wk_ready,
    output logic [31:0]  wk_data,
    output logic [5:0]   wk_index,
    output logic         done
);

    localparam int         NKW      = NK(KEY_SIZE);
    localparam int         NWW      = NW(KEY_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(NWW - 1);
    localparam logic [5:0] NK_IDX   = 6'(NKW);
    localparam logic [2:0] J_LAST   = 3'(NKW - 1);

    ks_state_t   state_q, state_d;
    word_t       win_q [NKW];
    word_t       win_d [NKW];
    word_t       data_q, data_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  j_q, j_d;
    logic [7:0]  rc_q, rc_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic [2:0]  j_nxt;
    logic [5:0]  idx_nxt;
    word_t       sub_in, sub_out, temp, next_word;
    logic        key_unused;

    assign key_unused = ^key;
    assign accept     = (state_q == S_EMIT) && valid_q && wk_ready;
    assign j_nxt      = (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
    assign idx_nxt    = idx_q + 6'd1;

    // The word being accepted becomes w[i-1] for the next word, so it feeds SubWord directly.
    assign sub_in = (j_nxt == 3'd0) ? {data_q[23:0], data_q[31:24]} : data_q;

    sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        temp = data_q;
        if (j_nxt == 3'd0) begin
            temp = sub_out ^ {rc_q, 24'h0};
        end else if (NKW == 8 && j_nxt == 3'd4) begin
            temp = sub_out;
        end
        // During the first Nk words the window is a rotating copy of the key.
        next_word = (idx_nxt >= NK_IDX) ? (win_q[1] ^ temp) : win_q[1];
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        data_d  = data_q;
        idx_d   = idx_q;
        j_d     = j_q;
        rc_d    = rc_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EMIT;
                    for (int k = 0; k < NKW; k++) begin
                        win_d[k] = key[255 - 32*k -: 32];
                    end
                    data_d  = key[255:224];
                    idx_d   = 6'd0;
                    j_d     = 3'd0;
                    rc_d    = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_EMIT: begin
                if (accept) begin
                    for (int k = 0; k < NKW - 1; k++) begin
                        win_d[k] = win_q[k + 1];
                    end
                    win_d[NKW - 1] = data_q;
                    if (j_q == 3'd0 && idx_q >= NK_IDX) begin
                        rc_d = xtime(rc_q);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = next_word;
                        idx_d  = idx_nxt;
                        j_d    = j_nxt;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int k = 0; k < NKW; k++) begin
                win_q[k] <= '0;
            end
            data_q  <= '0;
            idx_q   <= '0;
            j_q     <= '0;
            rc_q    <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign wk_valid = valid_q;
    assign wk_data  = data_q;
    assign wk_index = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: 128/192/256-bit instances run side by side against a
// FIPS-197 reference whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_sched;

    localparam int LIMIT = 2000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         wk_ready;
    logic [255:0] key_a   [3];
    logic         busy_a  [3];
    logic         valid_a [3];
    logic [31:0]  data_a  [3];
    logic [5:0]   index_a [3];
    logic         done_a  [3];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  sbox_tab [256];
    logic [31:0] exp_w    [3][60];
    logic [31:0] got      [3][60];
    logic [31:0] got_ref  [3][60];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        aes_key_sched #(.KEY_SIZE(128 + 64*gi)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .key      (key_a[gi]),
            .busy     (busy_a[gi]),
            .wk_valid (valid_a[gi]),
            .wk_ready (wk_ready),
            .wk_data  (data_a[gi]),
            .wk_index (index_a[gi]),
            .done     (done_a[gi])
        );
    end

    function automatic int nk_of(input int d);
        return 4 + 2*d;
    endfunction

    function automatic int nw_of(input int d);
        return 44 + 8*d;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_exp(input int d);
        int          nk = nk_of(d);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) exp_w[d][i] = key_a[d][255 - 32*i -: 32];
        for (int i = nk; i < nw_of(d); i++) begin
            t = exp_w[d][i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            exp_w[d][i] = exp_w[d][i-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_quiet(input string tag, input int d, input bit full);
        chk($sformatf("%s_valid_k%0d", tag, d), 32'(valid_a[d]), 32'd0);
        chk($sformatf("%s_busy_k%0d", tag, d), 32'(busy_a[d]), 32'd0);
        chk($sformatf("%s_done_k%0d", tag, d), 32'(done_a[d]), 32'd0);
        if (full) begin
            chk($sformatf("%s_data_k%0d", tag, d), data_a[d], 32'd0);
            chk($sformatf("%s_index_k%0d", tag, d), 32'(index_a[d]), 32'd0);
        end
    endtask

    task automatic run_exp(input int ready_pct, input bit spam, input int abort_at);
        int          cnt     [3];
        bit          fin     [3];
        bit          stalled [3];
        logic [31:0] held_d  [3];
        logic [5:0]  held_i  [3];
        int          cyc     = 0;
        bit          aborted = 1'b0;
        bit          all_act;
        for (int d = 0; d < 3; d++) begin
            build_exp(d);
            cnt[d] = 0; fin[d] = 1'b0; stalled[d] = 1'b0;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(fin[0] && fin[1] && fin[2]) && cyc < LIMIT && !aborted) begin
            for (int d = 0; d < 3; d++) begin
                if (fin[d]) begin
                    chk_quiet("idle", d, 1'b0);
                end else if (cnt[d] == nw_of(d)) begin
                    chk($sformatf("done_k%0d", d), 32'(done_a[d]), 32'd1);
                    chk($sformatf("end_valid_k%0d", d), 32'(valid_a[d]), 32'd0);
                    chk($sformatf("end_busy_k%0d", d), 32'(busy_a[d]), 32'd0);
                    chk($sformatf("end_index_k%0d", d), 32'(index_a[d]), 32'(nw_of(d) - 1));
                    fin[d] = 1'b1;
                end else begin
                    chk($sformatf("valid_k%0d_w%0d", d, cnt[d]), 32'(valid_a[d]), 32'd1);
                    chk($sformatf("busy_k%0d_w%0d", d, cnt[d]), 32'(busy_a[d]), 32'd1);
                    chk($sformatf("done_early_k%0d_w%0d", d, cnt[d]), 32'(done_a[d]), 32'd0);
                    chk($sformatf("index_k%0d_w%0d", d, cnt[d]), 32'(index_a[d]), 32'(cnt[d]));
                    chk($sformatf("data_k%0d_w%0d", d, cnt[d]), data_a[d], exp_w[d][cnt[d]]);
                    if (stalled[d]) begin
                        chk($sformatf("stall_data_k%0d_w%0d", d, cnt[d]), data_a[d], held_d[d]);
                        chk($sformatf("stall_index_k%0d_w%0d", d, cnt[d]), 32'(index_a[d]), 32'(held_i[d]));
                    end
                end
            end
            if (abort_at >= 0 && cnt[0] == abort_at) begin
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < 3; d++) chk_quiet("abort", d, 1'b1);
                @(negedge clk);
                for (int d = 0; d < 3; d++) chk_quiet("abort_hold", d, 1'b1);
                rst_n = 1'b1;
                @(negedge clk);
                for (int d = 0; d < 3; d++) chk_quiet("abort_rel", d, 1'b0);
                aborted = 1'b1;
            end else begin
                wk_ready = ($urandom_range(99) < ready_pct);
                all_act = 1'b1;
                for (int d = 0; d < 3; d++) if (!(valid_a[d] || done_a[d])) all_act = 1'b0;
                start = spam && all_act && ($urandom_range(1) == 1);
                for (int d = 0; d < 3; d++) begin
                    if (!fin[d] && valid_a[d] && wk_ready) begin
                        got[d][cnt[d]] = data_a[d];
                        cnt[d]++;
                        stalled[d] = 1'b0;
                    end else begin
                        stalled[d] = valid_a[d] && !wk_ready;
                        held_d[d]  = data_a[d];
                        held_i[d]  = index_a[d];
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        vectors++;
        assert (aborted || cyc < LIMIT) else begin
            miscompares++;
            $error("FAIL timeout cycles=%0d limit=%0d", cyc, LIMIT);
        end
    endtask

    task automatic set_fips_keys();
        key_a[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key_a[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        key_a[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    endtask

    initial begin
        build_sbox();
        rst_n    = 1'b0;
        start    = 1'b0;
        wk_ready = 1'b0;
        set_fips_keys();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_quiet("reset", d, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer run with ready held high.
        wk_ready = 1'b1;
        run_exp(100, 1'b0, -1);
        chk("kat128_w4", got[0][4], 32'ha0fafe17);
        chk("kat128_w43", got[0][43], 32'hb6630ca6);
        chk("kat192_w6", got[1][6], 32'hfe0c91f7);
        chk("kat192_w51", got[1][51], 32'h01002202);
        chk("kat256_w8", got[2][8], 32'h9ba35411);
        chk("kat256_w12", got[2][12], 32'ha8b09c1a);
        chk("kat256_w59", got[2][59], 32'h706c631e);
        got_ref = got;

        // Same keys under random backpressure must give the identical sequence.
        run_exp(50, 1'b0, -1);
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < nw_of(d); i++)
                chk($sformatf("bp_seq_k%0d_w%0d", d, i), got[d][i], got_ref[d][i]);

        // Start spammed throughout expansion.
        run_exp(100, 1'b1, -1);

        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 3; d++)
                key_a[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_exp(30 + int'($urandom_range(60)), 1'($urandom_range(1)), -1);
        end

        // Reset mid-expansion, then a clean restart.
        set_fips_keys();
        run_exp(100, 1'b0, 20);
        run_exp(100, 1'b0, -1);
        chk("restart_w0", got[0][0], 32'h2b7e1516);
        chk("restart_w43", got[0][43], 32'hb6630ca6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
